dmem_responder: RTL and testbench

- Data-memory responder for the pipelined CPU's memory-stage interface.
- Accepts M-stage load/store requests (address, write data, write enable) and services them from an internal word-addressed RAM.
- Inserts a parameterised number of wait states through a stall handshake, so the pipeline can be exercised against slow memory.
- Sits between the CPU core and the data-memory space, in place of an ideal zero-latency memory.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data memory responder with configurable wait states
module dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] alumultoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        misalignM
);
    localparam int         LP_DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] LP_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_BITS-1:0]  r_idx;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [31:0]           r_rdata;
    logic                  r_misalign;
    logic [31:0]           r_mem [LP_DEPTH];

    logic [ADDR_BITS-1:0]  w_in_idx;
    logic [ADDR_BITS-1:0]  w_acc_idx;
    logic [31:0]           w_acc_wdata;
    logic                  w_acc_we;
    logic                  w_valid;
    logic                  w_aligned;
    logic                  w_accept;
    logic                  w_finish;
    logic                  w_set_misalign;
    logic                  w_unused_addr;

    assign w_in_idx      = alumultoutM[ADDR_BITS+1:2];
    assign w_unused_addr = ^alumultoutM[31:ADDR_BITS+2];
    assign w_valid       = memreadM | memwriteM;
    assign w_aligned     = (alumultoutM[1:0] == 2'b00);
    assign misalignM     = r_misalign;

    always_comb begin
        w_next         = r_state;
        stallM         = 1'b0;
        readdataM      = 32'd0;
        w_accept       = 1'b0;
        w_finish       = 1'b0;
        w_set_misalign = 1'b0;
        w_acc_idx      = r_idx;
        w_acc_we       = r_we;
        w_acc_wdata    = r_wdata;
        if (WAIT_STATES == 0) begin
            w_acc_idx      = w_in_idx;
            w_acc_we       = memwriteM;
            w_acc_wdata    = writedataM;
            w_set_misalign = w_valid && !w_aligned;
            w_finish       = w_valid && w_aligned;
            if (w_valid && w_aligned && !memwriteM)
                readdataM = r_mem[w_in_idx];
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Access completes straight from IDLE when only one wait state is needed
                    w_acc_idx   = w_in_idx;
                    w_acc_we    = memwriteM;
                    w_acc_wdata = writedataM;
                    if (w_valid && w_aligned) begin
                        stallM   = 1'b1;
                        w_accept = 1'b1;
                        if (WAIT_STATES == 1) begin
                            w_next   = S_DONE;
                            w_finish = 1'b1;
                        end else begin
                            w_next = S_BUSY;
                        end
                    end else if (w_valid) begin
                        w_set_misalign = 1'b1;
                    end
                end
                S_BUSY: begin
                    stallM = 1'b1;
                    if (r_cnt == 4'd1) begin
                        w_next   = S_DONE;
                        w_finish = 1'b1;
                    end
                end
                S_DONE: begin
                    readdataM = r_rdata;
                    w_next    = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
        if (!rst) begin
            stallM         = 1'b0;
            readdataM      = 32'd0;
            w_finish       = 1'b0;
            w_set_misalign = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_finish && w_acc_we)
            r_mem[w_acc_idx] <= w_acc_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_in_idx;
                r_wdata <= writedataM;
                r_we    <= memwriteM;
                r_cnt   <= LP_CNT_LOAD;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish)
                r_rdata <= w_acc_we ? 32'd0 : r_mem[w_acc_idx];
            if (w_set_misalign)
                r_misalign <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at 2, 0 and 3 wait states
module tb_dmem_responder;
    int ws [3] = '{2, 0, 3};
    int pass_cnt = 0;
    int total_cnt = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd   [3];
    logic        wr   [3];
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic [31:0] rdata[3];
    logic        stall[3];
    logic        mis  [3];

    logic [31:0] m_mem  [3][256];
    bit          m_known[3][256];
    bit          m_mis  [3];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst_n), .memreadM(rd[0]), .memwriteM(wr[0]),
        .alumultoutM(addr[0]), .writedataM(wd[0]), .readdataM(rdata[0]),
        .stallM(stall[0]), .misalignM(mis[0]));
    dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst_n), .memreadM(rd[1]), .memwriteM(wr[1]),
        .alumultoutM(addr[1]), .writedataM(wd[1]), .readdataM(rdata[1]),
        .stallM(stall[1]), .misalignM(mis[1]));
    dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_n), .memreadM(rd[2]), .memwriteM(wr[2]),
        .alumultoutM(addr[2]), .writedataM(wd[2]), .readdataM(rdata[2]),
        .stallM(stall[2]), .misalignM(mis[2]));

    // One complete access on DUT d, checked against the word-array model.
    task automatic access(input int d, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] data);
        int          idx;
        int          n;
        bit          bad;
        bit          do_chk;
        logic [31:0] exp;
        idx    = (a / 4) % 256;
        exp    = 32'd0;
        if (r && !w && (a % 4 == 0)) exp = m_mem[d][idx];
        do_chk = w || (a % 4 != 0) || m_known[d][idx];
        @(posedge clk); #1;
        rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = data;
        @(negedge clk);
        if ((a % 4 != 0) || ws[d] == 0) begin
            total_cnt++;
            if (stall[d] !== 1'b0) $display("FAIL nostall dut%0d addr=%h got=%b want=0", d, a, stall[d]);
            else pass_cnt++;
        end else begin
            n = 0; bad = 0;
            while (stall[d] === 1'b1 && n < 40) begin
                if (rdata[d] !== 32'd0) bad = 1;
                n++;
                @(negedge clk);
            end
            total_cnt++;
            if (n != ws[d]) $display("FAIL stall_len dut%0d addr=%h got=%0d want=%0d", d, a, n, ws[d]);
            else pass_cnt++;
            total_cnt++;
            if (bad != 0) $display("FAIL rdata_in_stall dut%0d addr=%h got=nonzero want=0", d, a);
            else pass_cnt++;
        end
        if (do_chk) begin
            total_cnt++;
            if (rdata[d] !== exp) $display("FAIL rdata dut%0d addr=%h got=%h want=%h", d, a, rdata[d], exp);
            else pass_cnt++;
        end
        if (a % 4 != 0) m_mis[d] = 1;
        else if (w) begin m_mem[d][idx] = data; m_known[d][idx] = 1; end
        @(posedge clk); #1;
        rd[d] = 0; wr[d] = 0;
        @(negedge clk);
        total_cnt++;
        if (rdata[d] !== 32'd0 || stall[d] !== 1'b0)
            $display("FAIL idle dut%0d got rdata=%h stall=%b want 0/0", d, rdata[d], stall[d]);
        else pass_cnt++;
        total_cnt++;
        if (mis[d] !== m_mis[d]) $display("FAIL misalign dut%0d got=%b want=%b", d, mis[d], m_mis[d]);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1; wr[d] = 0; addr[d] = 32'h10; wd[d] = 0;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            total_cnt++;
            if (stall[d] !== 1'b0 || rdata[d] !== 32'd0 || mis[d] !== 1'b0)
                $display("FAIL reset dut%0d got stall=%b rdata=%h mis=%b want 0/0/0", d, stall[d], rdata[d], mis[d]);
            else pass_cnt++;
            rd[d] = 0;
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_ws2_basic();
        access(0, 0, 1, 32'h10, 32'hDEADBEEF);
        access(0, 1, 0, 32'h10, 32'h0);
    endtask

    task automatic test_ws0_back_to_back();
        @(posedge clk); #1;
        rd[1] = 0; wr[1] = 1; addr[1] = 32'h04; wd[1] = 32'h12345678;
        @(negedge clk);
        total_cnt++;
        if (stall[1] !== 1'b0 || rdata[1] !== 32'd0)
            $display("FAIL ws0_store got stall=%b rdata=%h want 0/0", stall[1], rdata[1]);
        else pass_cnt++;
        @(posedge clk); #1;
        rd[1] = 1; wr[1] = 0;
        #1;
        total_cnt++;
        if (stall[1] !== 1'b0 || rdata[1] !== 32'h12345678)
            $display("FAIL ws0_load got stall=%b rdata=%h want 0/12345678", stall[1], rdata[1]);
        else pass_cnt++;
        m_mem[1][1] = 32'h12345678; m_known[1][1] = 1;
        @(posedge clk); #1;
        rd[1] = 0;
    endtask

    task automatic test_alias_ws3();
        access(2, 0, 1, 32'h400, 32'hA5A5A5A5);
        access(2, 1, 0, 32'h000, 32'h0);
    endtask

    task automatic test_misalign();
        access(0, 1, 0, 32'h13, 32'h0);
        access(0, 0, 1, 32'h30, 32'h55AA55AA);
        access(0, 1, 0, 32'h10, 32'h0);
        access(1, 0, 1, 32'h22, 32'h99999999);
    endtask

    task automatic test_reset_in_busy();
        access(0, 0, 1, 32'h20, 32'h22222222);
        @(posedge clk); #1;
        wr[0] = 1; addr[0] = 32'h20; wd[0] = 32'h11111111;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (stall[0] !== 1'b1) $display("FAIL busy_stall got=%b want=1", stall[0]);
        else pass_cnt++;
        #1 rst_n = 0;
        #1;
        total_cnt++;
        if (stall[0] !== 1'b0 || rdata[0] !== 32'd0)
            $display("FAIL async_abort got stall=%b rdata=%h want 0/0", stall[0], rdata[0]);
        else pass_cnt++;
        wr[0] = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int d = 0; d < 3; d++) m_mis[d] = 0;
        access(0, 1, 0, 32'h20, 32'h0);
    endtask

    task automatic test_both_high();
        access(0, 1, 1, 32'h08, 32'h0F0F0F0F);
        access(0, 1, 0, 32'h08, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          r;
        bit          w;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 24; i++) begin
                a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 10);
                r = 1'($urandom_range(0, 1));
                w = (i < 4) ? 1'b1 : ~r | 1'($urandom_range(0, 3) == 0);
                access(d, r, w, a, $urandom);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rd[d] = 0; wr[d] = 0; addr[d] = 0; wd[d] = 0; m_mis[d] = 0;
        end
        test_reset();
        test_ws2_basic();
        test_ws0_back_to_back();
        test_alias_ws3();
        test_misalign();
        test_reset_in_busy();
        test_both_high();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
